// File: rtl/dcache_sram_nway.sv
// rtl/dcache_sram_nway.sv - N-way set-associative dcache storage array with true-LRU and victim reporting
module dcache_sram_nway #(
    parameter  int SETS   = 16,
    parameter  int WAYS   = 2,
    parameter  int TAG_W  = 23,
    parameter  int LINE_W = 256,
    localparam int IDX_W  = $clog2(SETS),
    localparam int WAY_W  = $clog2(WAYS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [1:0]        op_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              dirty_i,
    output logic              ack_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic [LINE_W-1:0] data_o,
    output logic              vic_valid_o,
    output logic              vic_dirty_o,
    output logic [TAG_W-1:0]  vic_tag_o,
    output logic [LINE_W-1:0] vic_data_o
);
    localparam logic [1:0]       OP_READ  = 2'b00;
    localparam logic [1:0]       OP_WRITE = 2'b01;
    localparam logic [1:0]       OP_FILL  = 2'b10;
    localparam logic [WAY_W-1:0] AGE_LRU  = WAY_W'(WAYS - 1);

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [LINE_W-1:0] line_q  [SETS][WAYS];

    logic              hit, any_inv;
    logic [WAY_W-1:0]  hit_way, inv_way, lru_way, vic_way, sel_way, sel_age;
    logic              do_touch, do_demote, do_store, do_inval, store_dirty, rep_en, rep_live;
    logic [LINE_W-1:0] out_data;
    logic [WAY_W-1:0]  age_nxt [WAYS];

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx_i][w] && tag_q[idx_i][w] == tag_i) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx_i][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[idx_i][w] == AGE_LRU) lru_way = WAY_W'(w);
        end
        vic_way = any_inv ? inv_way : lru_way;
        sel_way = hit ? hit_way : vic_way;
    end

    always_comb begin
        do_touch    = 1'b0;
        do_demote   = 1'b0;
        do_store    = 1'b0;
        do_inval    = 1'b0;
        store_dirty = 1'b0;
        rep_en      = !hit;
        out_data    = '0;
        case (op_i)
            OP_READ: begin
                do_touch = hit;
                if (hit) out_data = line_q[idx_i][hit_way];
            end
            OP_WRITE: begin
                do_touch    = hit;
                do_store    = hit;
                store_dirty = 1'b1;
                if (hit) out_data = data_i;
            end
            OP_FILL: begin
                do_touch    = 1'b1;
                do_store    = 1'b1;
                store_dirty = dirty_i;
                out_data    = data_i;
            end
            default: begin
                do_demote = hit;
                do_inval  = hit;
                rep_en    = hit;
                if (hit) out_data = line_q[idx_i][hit_way];
            end
        endcase
        rep_live = rep_en && valid_q[idx_i][sel_way];
    end

    always_comb begin
        sel_age = age_q[idx_i][sel_way];
        for (int w = 0; w < WAYS; w++) begin
            age_nxt[w] = age_q[idx_i][w];
            if (do_touch) begin
                if (WAY_W'(w) == sel_way)          age_nxt[w] = '0;
                else if (age_q[idx_i][w] < sel_age) age_nxt[w] = age_q[idx_i][w] + WAY_W'(1);
            end else if (do_demote) begin
                if (WAY_W'(w) == sel_way)          age_nxt[w] = AGE_LRU;
                else if (age_q[idx_i][w] > sel_age) age_nxt[w] = age_q[idx_i][w] - WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else if (req_i) begin
            for (int w = 0; w < WAYS; w++) age_q[idx_i][w] <= age_nxt[w];
            if (do_store) begin
                valid_q[idx_i][sel_way] <= 1'b1;
                dirty_q[idx_i][sel_way] <= store_dirty;
            end
            if (do_inval) begin
                valid_q[idx_i][sel_way] <= 1'b0;
                dirty_q[idx_i][sel_way] <= 1'b0;
            end
        end
    end

    // Tag/data storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk_i) begin
        if (req_i && do_store && !rst_i) begin
            tag_q[idx_i][sel_way]  <= tag_i;
            line_q[idx_i][sel_way] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o       <= 1'b0;
            hit_o       <= 1'b0;
            way_o       <= '0;
            data_o      <= '0;
            vic_valid_o <= 1'b0;
            vic_dirty_o <= 1'b0;
            vic_tag_o   <= '0;
            vic_data_o  <= '0;
        end else begin
            ack_o <= req_i;
            if (req_i) begin
                hit_o       <= hit;
                way_o       <= sel_way;
                data_o      <= out_data;
                vic_valid_o <= rep_live;
                vic_dirty_o <= rep_live && dirty_q[idx_i][sel_way];
                vic_tag_o   <= rep_live ? tag_q[idx_i][sel_way] : '0;
                vic_data_o  <= rep_live ? line_q[idx_i][sel_way] : '0;
            end
        end
    end
endmodule

// File: tb/tb_dcache_sram_nway.sv
// tb/tb_dcache_sram_nway.sv - directed scoreboard bench for dcache_sram_nway (2-way and 4-way instances)
module tb_dcache_sram_nway;
    typedef struct {
        logic         hit;
        logic [1:0]   way;
        logic [255:0] data;
        logic         vv;
        logic         vd;
        logic [22:0]  vt;
        logic [255:0] vdat;
    } exp_t;

    localparam logic [1:0] OPR = 2'b00, OPW = 2'b01, OPF = 2'b10, OPI = 2'b11;

    logic         clk = 1'b0;
    logic         rst, req2, req4, dirty;
    logic [1:0]   op;
    logic [3:0]   idx;
    logic [22:0]  tag;
    logic [255:0] din;

    logic         ack2, hit2, vv2, vd2, ack4, hit4, vv4, vd4;
    logic [0:0]   way2;
    logic [1:0]   way4;
    logic [255:0] data2, vdat2, data4, vdat4;
    logic [22:0]  vt2, vt4;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t zero_e;
    logic [255:0] dead;

    always #5 clk = ~clk;

    dcache_sram_nway #(.WAYS(2)) u_d2 (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .op_i(op), .idx_i(idx), .tag_i(tag),
        .data_i(din), .dirty_i(dirty), .ack_o(ack2), .hit_o(hit2), .way_o(way2),
        .data_o(data2), .vic_valid_o(vv2), .vic_dirty_o(vd2), .vic_tag_o(vt2), .vic_data_o(vdat2)
    );

    dcache_sram_nway #(.WAYS(4)) u_d4 (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .op_i(op), .idx_i(idx), .tag_i(tag),
        .data_i(din), .dirty_i(dirty), .ack_o(ack4), .hit_o(hit4), .way_o(way4),
        .data_o(data4), .vic_valid_o(vv4), .vic_dirty_o(vd4), .vic_tag_o(vt4), .vic_data_o(vdat4)
    );

    function automatic logic [255:0] ln(input logic [31:0] x);
        return {8{32'hC0DE0000 | x}};
    endfunction

    function automatic exp_t mk(input logic h, input logic [1:0] w, input logic [255:0] d,
                                input logic v, input logic vdy, input logic [22:0] t,
                                input logic [255:0] vd);
        exp_t e;
        e.hit = h; e.way = w; e.data = d; e.vv = v; e.vd = vdy; e.vt = t; e.vdat = vd;
        return e;
    endfunction

    task automatic chk(input string name, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic compare(input bit d4, input logic exp_ack, input exp_t e);
        chk(d4 ? "ack4" : "ack2", 512'(d4 ? ack4 : ack2), 512'(exp_ack));
        chk(d4 ? "hit4" : "hit2", 512'(d4 ? hit4 : hit2), 512'(e.hit));
        chk(d4 ? "way4" : "way2", 512'(d4 ? way4 : {1'b0, way2}), 512'(e.way));
        chk(d4 ? "data4" : "data2", 512'(d4 ? data4 : data2), 512'(e.data));
        chk(d4 ? "vic4" : "vic2",
            512'(d4 ? {vv4, vd4, vt4, vdat4} : {vv2, vd2, vt2, vdat2}),
            512'({e.vv, e.vd, e.vt, e.vdat}));
    endtask

    task automatic issue(input bit d4, input logic [1:0] o, input logic [3:0] i,
                         input logic [22:0] t, input logic [255:0] d, input logic dy,
                         input exp_t e);
        exp_t h;
        op = o; idx = i; tag = t; din = d; dirty = dy;
        req2 = !d4; req4 = d4;
        sb.push_back(e);
        @(posedge clk); #1;
        req2 = 1'b0; req4 = 1'b0;
        h = sb.pop_front();
        compare(d4, 1'b1, h);
    endtask

    initial begin
        zero_e = mk(0, 0, '0, 0, 0, '0, '0);
        dead   = {8{32'hDEADBEEF}};
        rst = 1'b1; req2 = 1'b0; req4 = 1'b0; dirty = 1'b0;
        op = OPR; idx = '0; tag = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        compare(0, 1'b0, zero_e);
        compare(1, 1'b0, zero_e);
        rst = 1'b0;

        // Cold miss on reset state
        issue(0, OPR, 3, 23'h1A, '0, 0, mk(0, 0, '0, 0, 0, '0, '0));

        // 4-way LRU ordering and victim selection
        issue(1, OPF, 5, 23'hA, ln(32'hA), 0, mk(0, 0, ln(32'hA), 0, 0, '0, '0));
        issue(1, OPF, 5, 23'hB, ln(32'hB), 0, mk(0, 1, ln(32'hB), 0, 0, '0, '0));
        issue(1, OPF, 5, 23'hC, ln(32'hC), 0, mk(0, 2, ln(32'hC), 0, 0, '0, '0));
        issue(1, OPF, 5, 23'hD, ln(32'hD), 0, mk(0, 3, ln(32'hD), 0, 0, '0, '0));
        issue(1, OPR, 5, 23'hA, '0, 0, mk(1, 0, ln(32'hA), 0, 0, '0, '0));
        issue(1, OPF, 5, 23'hE, ln(32'hE), 0, mk(0, 1, ln(32'hE), 1, 0, 23'hB, ln(32'hB)));
        issue(1, OPR, 5, 23'hB, '0, 0, mk(0, 2, '0, 1, 0, 23'hC, ln(32'hC)));
        issue(1, OPI, 5, 23'hE, '0, 0, mk(1, 1, ln(32'hE), 1, 0, 23'hE, ln(32'hE)));
        issue(1, OPR, 5, 23'hF, '0, 0, mk(0, 1, '0, 0, 0, '0, '0));
        issue(1, OPI, 5, 23'h55, '0, 0, mk(0, 1, '0, 0, 0, '0, '0));

        // Dirty write-back victim in 2-way
        issue(0, OPF, 7, 23'h7, ln(32'h7), 0, mk(0, 0, ln(32'h7), 0, 0, '0, '0));
        issue(0, OPW, 7, 23'h7, dead, 0, mk(1, 0, dead, 0, 0, '0, '0));
        issue(0, OPF, 7, 23'h8, ln(32'h8), 0, mk(0, 1, ln(32'h8), 0, 0, '0, '0));
        issue(0, OPF, 7, 23'h9, ln(32'h9), 0, mk(0, 0, ln(32'h9), 1, 1, 23'h7, dead));

        // Refill of a resident tag overwrites in place
        issue(0, OPF, 9, 23'h7, ln(32'h71), 0, mk(0, 0, ln(32'h71), 0, 0, '0, '0));
        issue(0, OPF, 9, 23'h7, ln(32'h72), 1, mk(1, 0, ln(32'h72), 0, 0, '0, '0));
        issue(0, OPR, 9, 23'h7, '0, 0, mk(1, 0, ln(32'h72), 0, 0, '0, '0));

        // Back-to-back write then read, then outputs hold while idle
        issue(0, OPF, 2, 23'h30, ln(32'h30), 0, mk(0, 0, ln(32'h30), 0, 0, '0, '0));
        issue(0, OPW, 2, 23'h30, ln(32'h31), 0, mk(1, 0, ln(32'h31), 0, 0, '0, '0));
        issue(0, OPR, 2, 23'h30, '0, 0, mk(1, 0, ln(32'h31), 0, 0, '0, '0));
        @(posedge clk); #1;
        compare(0, 1'b0, mk(1, 0, ln(32'h31), 0, 0, '0, '0));

        // Reset while a request is in flight
        issue(0, OPF, 11, 23'h44, ln(32'h44), 0, mk(0, 0, ln(32'h44), 0, 0, '0, '0));
        op = OPF; idx = 11; tag = 23'h45; din = ln(32'h45); req2 = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        req2 = 1'b0;
        compare(0, 1'b0, zero_e);
        compare(1, 1'b0, zero_e);
        rst = 1'b0;
        issue(0, OPR, 11, 23'h44, '0, 0, mk(0, 0, '0, 0, 0, '0, '0));

        chk("sb_empty", 512'(sb.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
